// File: rtl/rnbip_pkg.sv
// Shared types for the RNBIP sequencing pipeline: the per-stage instruction
// record and the forwarding-select constant that means "use the register array".
package rnbip_pkg;

    // Record fields are sized for the widest supported core; narrower
    // instances zero-extend on entry and slice on exit.
    localparam int PKG_DW  = 16;
    localparam int PKG_AW  = 5;
    localparam int PKG_OPW = 16;

    localparam logic [2:0] FWD_RF = 3'd0;

    typedef struct packed {
        logic               valid;
        logic [PKG_OPW-1:0] opcode;
        logic [PKG_DW-1:0]  npc;
        logic [PKG_DW-1:0]  operand;
        logic [PKG_AW-1:0]  rs_addr;
        logic               rs_use;
        logic [PKG_AW-1:0]  rd_addr;
        logic               rd_we;
        logic               rd_mem;
    } stage_rec_t;

    // A producer sitting in stage j is forwarded with select j-1.
    function automatic logic [2:0] stage_to_fwd(input int j);
        return 3'(j - 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// RAW hazard detection for the decode stage: compares its source register
// against the destinations of stages 2..STAGES-1 and picks forward or stall.
module pipe_hazard_unit
    import rnbip_pkg::*;
#(
    parameter int STAGES = 3,
    parameter bit FWD_EN = 1'b1
) (
    input  stage_rec_t [STAGES:1] stg,
    output logic                  stall,
    output logic [2:0]            fwd_sel
);

    logic unused_fields;
    assign unused_fields = ^stg;

    // Walk from oldest to youngest so the youngest matching producer ends up
    // deciding the result. The execute stage is skipped: its write lands in
    // the write-first register array this same cycle.
    always_comb begin
        stall   = 1'b0;
        fwd_sel = FWD_RF;
        for (int j = STAGES - 1; j >= 2; j--) begin
            if (stg[1].valid && stg[1].rs_use && stg[j].valid && stg[j].rd_we &&
                (stg[j].rd_addr == stg[1].rs_addr)) begin
                if (FWD_EN && !stg[j].rd_mem) begin
                    stall   = 1'b0;
                    fwd_sel = stage_to_fwd(j);
                end else begin
                    stall   = 1'b1;
                    fwd_sel = FWD_RF;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Parametrised instruction-sequencing pipeline: carries fetched fields through
// STAGES registers, forwards or stalls on RAW hazards, flushes on taken branches.
module pipe_seq_ctrl
    import rnbip_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter int OPW    = 8,
    parameter int STAGES = 3,
    parameter bit FWD_EN = 1'b1,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [OPW-1:0]  if_opcode,
    input  logic [DW-1:0]   if_npc,
    input  logic [DW-1:0]   if_operand,
    input  logic [AW-1:0]   if_rs_addr,
    input  logic            if_rs_use,
    input  logic [AW-1:0]   if_rd_addr,
    input  logic            if_rd_we,
    input  logic            if_rd_mem,
    input  logic            br_taken,
    output logic            ex_valid,
    output logic [OPW-1:0]  ex_opcode,
    output logic [DW-1:0]   ex_npc,
    output logic [DW-1:0]   ex_operand,
    output logic [AW-1:0]   ex_rd_addr,
    output logic            ex_rd_we,
    output logic [2:0]      fwd_sel,
    output logic            stall,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    if (STAGES < 2 || STAGES > 5) begin : g_bad_stages
        $error("pipe_seq_ctrl: STAGES must be in 2..5");
    end
    if (DW > PKG_DW || AW > PKG_AW || OPW > PKG_OPW) begin : g_bad_widths
        $error("pipe_seq_ctrl: field width exceeds stage record width");
    end

    stage_rec_t [STAGES:1] stg;
    stage_rec_t            fetch_rec;
    logic                  haz_stall;
    logic [2:0]            haz_fwd;
    logic                  accept;

    pipe_hazard_unit #(
        .STAGES (STAGES),
        .FWD_EN (FWD_EN)
    ) u_hazard (
        .stg     (stg),
        .stall   (haz_stall),
        .fwd_sel (haz_fwd)
    );

    assign stall    = haz_stall;
    assign fwd_sel  = haz_fwd;
    assign if_ready = !rst && !haz_stall && !br_taken;
    assign accept   = if_valid && if_ready;

    always_comb begin
        fetch_rec         = '0;
        fetch_rec.valid   = 1'b1;
        fetch_rec.opcode  = PKG_OPW'(if_opcode);
        fetch_rec.npc     = PKG_DW'(if_npc);
        fetch_rec.operand = PKG_DW'(if_operand);
        fetch_rec.rs_addr = PKG_AW'(if_rs_addr);
        fetch_rec.rs_use  = if_rs_use;
        fetch_rec.rd_addr = PKG_AW'(if_rd_addr);
        fetch_rec.rd_we   = if_rd_we;
        fetch_rec.rd_mem  = if_rd_mem;
    end

    // A taken branch kills everything younger than execute; execute itself
    // retires at the same edge, so the whole pipe comes out empty.
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        stage_rec_t q;
        if (k == 1) begin : g_decode
            always_ff @(posedge clk) begin
                if (rst || br_taken) q <= '0;
                else if (!haz_stall) q <= accept ? fetch_rec : '0;
            end
        end else if (k == 2) begin : g_bubble
            always_ff @(posedge clk) begin
                if (rst || br_taken || haz_stall) q <= '0;
                else q <= stg[1];
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst || br_taken) q <= '0;
                else q <= stg[k-1];
            end
        end
        assign stg[k] = q;
    end

    // A flush overrides a coincident stall, so only one counter moves per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (br_taken) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (haz_stall) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ex_valid   = stg[STAGES].valid;
    assign ex_opcode  = stg[STAGES].valid ? stg[STAGES].opcode[OPW-1:0] : '0;
    assign ex_npc     = stg[STAGES].npc[DW-1:0];
    assign ex_operand = stg[STAGES].operand[DW-1:0];
    assign ex_rd_addr = stg[STAGES].rd_addr[AW-1:0];
    assign ex_rd_we   = stg[STAGES].valid && stg[STAGES].rd_we;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: four instances (3-stage fwd, 3-stage no-fwd,
// 5-stage fwd, 3-stage with 2-bit counters) share one stimulus stream.
module tb_pipe_seq_ctrl;

    localparam int ND = 4;
    localparam int ST_P [0:ND-1] = '{3, 3, 5, 3};
    localparam int FW_P [0:ND-1] = '{1, 0, 1, 1};
    localparam int MAXC [0:ND-1] = '{65535, 65535, 65535, 3};

    logic       clk;
    logic       rst;
    logic       if_valid;
    logic [7:0] if_opcode;
    logic [7:0] if_npc;
    logic [7:0] if_operand;
    logic [2:0] if_rs_addr;
    logic       if_rs_use;
    logic [2:0] if_rd_addr;
    logic       if_rd_we;
    logic       if_rd_mem;
    logic       br_taken;

    logic        if_ready_w   [ND];
    logic        ex_valid_w   [ND];
    logic [7:0]  ex_opcode_w  [ND];
    logic [7:0]  ex_npc_w     [ND];
    logic [7:0]  ex_operand_w [ND];
    logic [2:0]  ex_rd_addr_w [ND];
    logic        ex_rd_we_w   [ND];
    logic [2:0]  fwd_sel_w    [ND];
    logic        stall_w      [ND];
    logic [15:0] stall_cnt_w  [ND];
    logic [15:0] flush_cnt_w  [ND];
    logic [1:0]  sc_narrow;
    logic [1:0]  fc_narrow;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        if (g < ND - 1) begin : g_wide
            pipe_seq_ctrl #(.STAGES(ST_P[g]), .FWD_EN(FW_P[g] == 1), .CNTW(16)) u_dut (
                .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready_w[g]),
                .if_opcode(if_opcode), .if_npc(if_npc), .if_operand(if_operand),
                .if_rs_addr(if_rs_addr), .if_rs_use(if_rs_use), .if_rd_addr(if_rd_addr),
                .if_rd_we(if_rd_we), .if_rd_mem(if_rd_mem), .br_taken(br_taken),
                .ex_valid(ex_valid_w[g]), .ex_opcode(ex_opcode_w[g]), .ex_npc(ex_npc_w[g]),
                .ex_operand(ex_operand_w[g]), .ex_rd_addr(ex_rd_addr_w[g]),
                .ex_rd_we(ex_rd_we_w[g]), .fwd_sel(fwd_sel_w[g]), .stall(stall_w[g]),
                .stall_cnt(stall_cnt_w[g]), .flush_cnt(flush_cnt_w[g])
            );
        end else begin : g_narrow
            pipe_seq_ctrl #(.STAGES(ST_P[g]), .FWD_EN(FW_P[g] == 1), .CNTW(2)) u_dut (
                .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready_w[g]),
                .if_opcode(if_opcode), .if_npc(if_npc), .if_operand(if_operand),
                .if_rs_addr(if_rs_addr), .if_rs_use(if_rs_use), .if_rd_addr(if_rd_addr),
                .if_rd_we(if_rd_we), .if_rd_mem(if_rd_mem), .br_taken(br_taken),
                .ex_valid(ex_valid_w[g]), .ex_opcode(ex_opcode_w[g]), .ex_npc(ex_npc_w[g]),
                .ex_operand(ex_operand_w[g]), .ex_rd_addr(ex_rd_addr_w[g]),
                .ex_rd_we(ex_rd_we_w[g]), .fwd_sel(fwd_sel_w[g]), .stall(stall_w[g]),
                .stall_cnt(sc_narrow), .flush_cnt(fc_narrow)
            );
            assign stall_cnt_w[g] = {14'd0, sc_narrow};
            assign flush_cnt_w[g] = {14'd0, fc_narrow};
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit       v;
        bit [7:0] op;
        bit [7:0] npc;
        bit [7:0] opd;
        bit [2:0] rs;
        bit       rs_use;
        bit [2:0] rd;
        bit       we;
        bit       mem;
    } ins_t;

    ins_t mp [0:ND-1][1:5];
    ins_t empty_ins;
    int   m_scnt [ND];
    int   m_fcnt [ND];
    bit   m_s    [ND];
    bit   m_rdy  [ND];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_ex0;
    int first_ex2;
    int fwd1_cyc0;
    int stall_cyc0;
    logic [7:0] ex_q0 [$];
    logic [7:0] ex_q2 [$];
    logic [7:0] exp_q [$];
    bit [7:0]   npc_ctr = 8'd0;

    function automatic void m_haz(input int d, output bit s, output bit [2:0] f);
        bit found;
        found = 1'b0;
        s = 1'b0;
        f = 3'd0;
        // Youngest producer first: the first match found is the one that counts.
        for (int j = 2; j <= ST_P[d] - 1; j++) begin
            if (!found && mp[d][1].v && mp[d][1].rs_use && mp[d][j].v && mp[d][j].we &&
                mp[d][j].rd == mp[d][1].rs) begin
                found = 1'b1;
                if (FW_P[d] == 1 && !mp[d][j].mem) f = 3'(j - 1);
                else s = 1'b1;
            end
        end
    endfunction

    function automatic ins_t fetch_now();
        ins_t t;
        t.v = 1'b1;       t.op = if_opcode;      t.npc = if_npc;
        t.opd = if_operand; t.rs = if_rs_addr;   t.rs_use = if_rs_use;
        t.rd = if_rd_addr; t.we = if_rd_we;      t.mem = if_rd_mem;
        return t;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; checks before the next edge, then advances.
    task automatic cycle();
        bit       s;
        bit [2:0] f;
        ins_t     top;
        ins_t     fe;
        #3;
        for (int d = 0; d < ND; d++) begin
            m_haz(d, s, f);
            m_s[d]   = s;
            m_rdy[d] = !rst && !s && !br_taken;
            top = mp[d][ST_P[d]];
            chk("if_ready",   d, 32'(if_ready_w[d]),   32'(m_rdy[d]));
            chk("stall",      d, 32'(stall_w[d]),      32'(s));
            chk("fwd_sel",    d, 32'(fwd_sel_w[d]),    32'(f));
            chk("ex_valid",   d, 32'(ex_valid_w[d]),   32'(top.v));
            chk("ex_opcode",  d, 32'(ex_opcode_w[d]),  top.v ? 32'(top.op) : 32'd0);
            chk("ex_npc",     d, 32'(ex_npc_w[d]),     32'(top.npc));
            chk("ex_operand", d, 32'(ex_operand_w[d]), 32'(top.opd));
            chk("ex_rd_addr", d, 32'(ex_rd_addr_w[d]), 32'(top.rd));
            chk("ex_rd_we",   d, 32'(ex_rd_we_w[d]),   32'(top.v && top.we));
            chk("stall_cnt",  d, 32'(stall_cnt_w[d]),  32'(m_scnt[d]));
            chk("flush_cnt",  d, 32'(flush_cnt_w[d]),  32'(m_fcnt[d]));
        end
        if (ex_valid_w[0]) begin
            ex_q0.push_back(ex_opcode_w[0]);
            if (first_ex0 < 0) first_ex0 = cyc;
        end
        if (ex_valid_w[2]) begin
            ex_q2.push_back(ex_opcode_w[2]);
            if (first_ex2 < 0) first_ex2 = cyc;
        end
        if (fwd_sel_w[0] == 3'd1) fwd1_cyc0++;
        if (stall_w[0]) stall_cyc0++;
        fe = fetch_now();
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                for (int k = 1; k <= 5; k++) mp[d][k] = empty_ins;
                m_scnt[d] = 0;
                m_fcnt[d] = 0;
            end else if (br_taken) begin
                for (int k = 1; k <= 5; k++) mp[d][k] = empty_ins;
                if (m_fcnt[d] < MAXC[d]) m_fcnt[d]++;
            end else if (m_s[d]) begin
                if (m_scnt[d] < MAXC[d]) m_scnt[d]++;
                for (int k = ST_P[d]; k >= 3; k--) mp[d][k] = mp[d][k-1];
                mp[d][2] = empty_ins;
            end else begin
                for (int k = ST_P[d]; k >= 2; k--) mp[d][k] = mp[d][k-1];
                mp[d][1] = (if_valid && m_rdy[d]) ? fe : empty_ins;
            end
        end
        cyc++;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input bit [7:0] op, input bit [2:0] rs, input bit use_rs,
                         input bit [2:0] rd, input bit we, input bit mem);
        if_valid   = 1'b1;
        if_opcode  = op;
        if_npc     = npc_ctr;
        npc_ctr    = npc_ctr + 8'd1;
        if_operand = 8'($urandom_range(0, 255));
        if_rs_addr = rs;
        if_rs_use  = use_rs;
        if_rd_addr = rd;
        if_rd_we   = we;
        if_rd_mem  = mem;
        cycle();
    endtask

    task automatic idle(input int n);
        if_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_tracking();
        ex_q0.delete();
        ex_q2.delete();
        first_ex0  = -1;
        first_ex2  = -1;
        fwd1_cyc0  = 0;
        stall_cyc0 = 0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t2_start;
        for (int d = 0; d < ND; d++) begin
            for (int k = 1; k <= 5; k++) mp[d][k] = empty_ins;
            m_scnt[d] = 0;
            m_fcnt[d] = 0;
        end
        clear_tracking();
        rst = 1'b1;
        br_taken = 1'b0;
        if_valid = 1'b1;
        if_opcode = 8'h55; if_npc = 8'h00; if_operand = 8'h00;
        if_rs_addr = 3'd0; if_rs_use = 1'b0; if_rd_addr = 3'd0;
        if_rd_we = 1'b0; if_rd_mem = 1'b0;

        // Reset held two cycles with a fetch offered.
        @(posedge clk);
        #1;
        cyc++;
        cycle();
        rst = 1'b0;
        #2;
        chk("rdy_after_rst", 0, 32'(if_ready_w[0]), 32'd1);
        cycle();
        idle(6);

        // Independent stream.
        clear_tracking();
        t2_start = cyc;
        issue(8'h10, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        issue(8'h20, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        issue(8'h30, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        idle(8);
        exp_q = '{8'h10, 8'h20, 8'h30};
        chk("t2_count", 0, 32'(ex_q0.size()), 32'd3);
        chk("t2_count", 2, 32'(ex_q2.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_op", 0, (i < ex_q0.size()) ? 32'(ex_q0[i]) : 32'hffff, 32'(exp_q[i]));
            chk("t2_op", 2, (i < ex_q2.size()) ? 32'(ex_q2[i]) : 32'hffff, 32'(exp_q[i]));
        end
        chk("t2_latency", 0, 32'(first_ex0 - t2_start), 32'd3);
        chk("t2_latency", 2, 32'(first_ex2 - t2_start), 32'd5);
        chk("t2_no_stall", 0, 32'(stall_cyc0), 32'd0);

        // Forwarding: ADD r2 then MOV reading r2.
        clear_tracking();
        issue(8'h21, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        issue(8'h41, 3'd2, 1'b1, 3'd4, 1'b1, 1'b0);
        idle(8);
        chk("t3_fwd_cycles", 0, 32'(fwd1_cyc0), 32'd1);
        chk("t3_no_stall", 0, 32'(stall_cyc0), 32'd0);
        chk("t3_stall_cnt", 1, 32'(stall_cnt_w[1]), 32'd1);

        // Load-use: LD r3 then use r3.
        clear_tracking();
        issue(8'h61, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        issue(8'h42, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0);
        idle(8);
        chk("t4_stall_cnt", 0, 32'(stall_cnt_w[0]), 32'd1);
        chk("t4_stall_cnt", 1, 32'(stall_cnt_w[1]), 32'd2);
        chk("t4_stall_cnt", 2, 32'(stall_cnt_w[2]), 32'd3);
        chk("t4_ex_count", 0, 32'(ex_q0.size()), 32'd2);

        // Flush with stages 1..2 occupied; the offered fetch comes back next cycle.
        clear_tracking();
        issue(8'h71, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
        issue(8'h72, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
        br_taken = 1'b1;
        issue(8'h73, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
        br_taken = 1'b0;
        cycle();
        idle(8);
        chk("t5_flush_cnt", 0, 32'(flush_cnt_w[0]), 32'd1);
        chk("t5_ex_count", 0, 32'(ex_q0.size()), 32'd1);
        chk("t5_ex_op", 0, (ex_q0.size() > 0) ? 32'(ex_q0[0]) : 32'hffff, 32'h73);

        // Branch coincident with a load-use stall.
        issue(8'h62, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
        issue(8'h43, 3'd3, 1'b1, 3'd5, 1'b1, 1'b0);
        if_valid = 1'b0;
        br_taken = 1'b1;
        cycle();
        br_taken = 1'b0;
        idle(6);
        chk("t6_stall_cnt", 0, 32'(stall_cnt_w[0]), 32'd1);
        chk("t6_flush_cnt", 0, 32'(flush_cnt_w[0]), 32'd2);

        // Five more load-use stalls: the 2-bit counter pins at 3.
        for (int i = 0; i < 5; i++) begin
            issue(8'h63, 3'd0, 1'b0, 3'd6, 1'b1, 1'b1);
            issue(8'h44, 3'd6, 1'b1, 3'd7, 1'b1, 1'b0);
            idle(6);
        end
        chk("t6_sat", 3, 32'(stall_cnt_w[3]), 32'd3);
        chk("t6_wide", 0, 32'(stall_cnt_w[0]), 32'd6);

        // Randomised traffic with occasional branches and mid-run resets.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 63) == 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            if_valid   = ($urandom_range(0, 3) != 0);
            if_opcode  = 8'($urandom_range(0, 255));
            if_npc     = 8'($urandom_range(0, 255));
            if_operand = 8'($urandom_range(0, 255));
            if_rs_addr = 3'($urandom_range(0, 3));
            if_rs_use  = 1'($urandom_range(0, 1));
            if_rd_addr = 3'($urandom_range(0, 3));
            if_rd_we   = 1'($urandom_range(0, 1));
            if_rd_mem  = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 1'b0;
        br_taken = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
